// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, tracks imem request/grant/response traffic,
// and buffers up to two fetched words in order for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  logic [31:0] pc;
  logic [1:0]  slot_alloc;
  logic [1:0]  slot_filled;
  logic [31:0] slot_pc   [2];
  logic [31:0] slot_data [2];
  logic        head;
  logic        tail;
  logic [1:0]  discard_cnt;

  logic        grant;
  logic        pop;
  logic        fill;
  logic        fill_hit;
  logic        fill_idx;
  logic        resp_drop;
  logic [1:0]  unfilled;
  logic [1:0]  unfilled_cnt;
  logic [1:0]  pending_cnt;
  logic [1:0]  redirect_discard;
  logic        unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  always_comb begin
    imem_req    = rst && !(&slot_alloc) && (discard_cnt == 2'd0) && !redirect_valid;
    imem_addr   = pc;
    grant       = imem_req && imem_gnt;
    instr_valid = slot_alloc[head] && slot_filled[head];
    instr       = slot_data[head];
    instr_pc    = slot_pc[head];
    pop         = instr_valid && instr_ready;
    unfilled    = slot_alloc & ~slot_filled;

    // Slots are allocated in order starting at head, so the oldest unfilled
    // slot is head if it is waiting, otherwise the one behind it.
    fill_hit = 1'b0;
    fill_idx = head;
    if (unfilled[head]) begin
      fill_hit = 1'b1;
      fill_idx = head;
    end else if (unfilled[~head]) begin
      fill_hit = 1'b1;
      fill_idx = ~head;
    end

    resp_drop = imem_rvalid && (discard_cnt != 2'd0);
    fill      = imem_rvalid && (discard_cnt == 2'd0) && fill_hit;

    // Every response still owed to memory after this cycle must be dropped.
    unfilled_cnt     = {1'b0, unfilled[0]} + {1'b0, unfilled[1]};
    pending_cnt      = unfilled_cnt - {1'b0, fill};
    redirect_discard = pending_cnt + (resp_drop ? discard_cnt - 2'd1 : discard_cnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      slot_alloc  <= 2'b00;
      slot_filled <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        slot_pc[i]   <= 32'h0;
        slot_data[i] <= 32'h0;
      end
      head        <= 1'b0;
      tail        <= 1'b0;
      discard_cnt <= 2'd0;
    end else if (redirect_valid) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      slot_alloc  <= 2'b00;
      slot_filled <= 2'b00;
      head        <= 1'b0;
      tail        <= 1'b0;
      discard_cnt <= redirect_discard;
    end else begin
      if (grant) begin
        slot_alloc[tail]  <= 1'b1;
        slot_filled[tail] <= 1'b0;
        slot_pc[tail]     <= pc;
        tail              <= ~tail;
        pc                <= pc + 32'd4;
      end
      if (fill) begin
        slot_filled[fill_idx] <= 1'b1;
        slot_data[fill_idx]   <= imem_rdata;
      end
      if (resp_drop) begin
        discard_cnt <= discard_cnt - 2'd1;
      end
      if (pop) begin
        slot_alloc[head]  <= 1'b0;
        slot_filled[head] <= 1'b0;
        head              <= ~head;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table of expected req/addr/valid/pc plus an
// in-order memory model and a scoreboard of granted PCs checked at decode.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    int          lat;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] eipc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  vec_t        tbl[$];
  mem_t        mem_q[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_vld;
  logic [31:0] s_instr;
  logic [31:0] s_ipc;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_5A17;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc, input int lat,
                     input logic ereq, input logic [31:0] eaddr, input logic evld,
                     input logic [31:0] eipc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.lat = lat;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.eipc = eipc;
    tbl.push_back(v);
  endtask

  // One clock cycle: drive memory, sample DUT, update models, cross the edge.
  task automatic tick();
    mem_t m;
    imem_gnt = 1'b1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data_of(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_vld   = instr_valid;
    s_instr = instr;
    s_ipc   = instr_pc;
    if (instr_valid && instr_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL hs_unexpected: got pc %h expected no handshake", instr_pc);
      end else begin
        chk($sformatf("hs_pc_c%0d", cyc), instr_pc, exp_q[0]);
        chk($sformatf("hs_instr_c%0d", cyc), instr, data_of(exp_q[0]));
        exp_q.delete(0);
      end
    end
    if (redirect_valid) exp_q.delete();
    if (imem_req && imem_gnt) begin
      exp_q.push_back(imem_addr);
      m.addr = imem_addr;
      m.due  = cyc + mem_lat;
      mem_q.push_back(m);
    end
    if (imem_rvalid) mem_q.delete(0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int base;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    instr_ready    = 1'b0;

    // rdy rv rpc lat | req addr vld ipc
    add(1, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    add(1, 0, 0, 1, 1, 32'h0000_0000, 0, 0);
    add(1, 0, 0, 1, 0, 32'h0000_0004, 1, 32'hFFFF_FFFC);
    add(1, 0, 0, 1, 1, 32'h0000_0004, 1, 32'h0000_0000);
    add(1, 0, 0, 1, 1, 32'h0000_0008, 0, 0);
    add(1, 0, 0, 1, 0, 32'h0000_000C, 1, 32'h0000_0004);
    add(1, 0, 0, 1, 1, 32'h0000_000C, 1, 32'h0000_0008);
    add(0, 1, 32'h0, 1, 0, 32'h0000_0010, 0, 0);
    add(0, 0, 0, 1, 1, 32'h0000_0000, 0, 0);
    add(0, 0, 0, 1, 1, 32'h0000_0004, 0, 0);
    add(0, 0, 0, 1, 0, 32'h0000_0008, 1, 32'h0000_0000);
    add(0, 0, 0, 1, 0, 32'h0000_0008, 1, 32'h0000_0000);
    add(1, 0, 0, 1, 0, 32'h0000_0008, 1, 32'h0000_0000);
    add(0, 0, 0, 1, 1, 32'h0000_0008, 1, 32'h0000_0004);
    add(0, 0, 0, 1, 0, 32'h0000_000C, 1, 32'h0000_0004);
    add(1, 0, 0, 3, 0, 32'h0000_000C, 1, 32'h0000_0004);
    add(1, 0, 0, 3, 1, 32'h0000_000C, 1, 32'h0000_0008);
    add(1, 0, 0, 3, 1, 32'h0000_0010, 0, 0);
    add(1, 1, 32'h103, 3, 0, 32'h0000_0014, 0, 0);
    add(1, 0, 0, 3, 0, 32'h0000_0100, 0, 0);
    add(1, 0, 0, 3, 0, 32'h0000_0100, 0, 0);
    add(1, 0, 0, 3, 1, 32'h0000_0100, 0, 0);
    add(1, 0, 0, 3, 1, 32'h0000_0104, 0, 0);
    add(1, 0, 0, 3, 0, 32'h0000_0108, 0, 0);
    add(1, 0, 0, 3, 0, 32'h0000_0108, 0, 0);
    add(1, 0, 0, 3, 0, 32'h0000_0108, 1, 32'h0000_0100);
    add(1, 0, 0, 3, 1, 32'h0000_0108, 1, 32'h0000_0104);
    add(1, 0, 0, 3, 1, 32'h0000_010C, 0, 0);
    add(1, 0, 0, 3, 0, 32'h0000_0110, 0, 0);
    add(0, 0, 0, 3, 0, 32'h0000_0110, 0, 0);
    add(0, 0, 0, 3, 0, 32'h0000_0110, 1, 32'h0000_0108);
    add(0, 0, 0, 3, 0, 32'h0000_0110, 1, 32'h0000_0108);

    repeat (2) @(posedge clk);
    #3;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      instr_ready    = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      mem_lat        = tbl[i].lat;
      tick();
      chk($sformatf("c%0d_req", i), {31'b0, s_req}, {31'b0, tbl[i].ereq});
      chk($sformatf("c%0d_addr", i), s_addr, tbl[i].eaddr);
      chk($sformatf("c%0d_valid", i), {31'b0, s_vld}, {31'b0, tbl[i].evld});
      if (tbl[i].evld) begin
        chk($sformatf("c%0d_ipc", i), s_ipc, tbl[i].eipc);
        chk($sformatf("c%0d_instr", i), s_instr, data_of(tbl[i].eipc));
      end
    end
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Asynchronous reset with a full buffer, mid-cycle.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, instr_valid}, 32'h0);
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, RST_PC);
    chk("arst_ipc", instr_pc, 32'h0);
    exp_q.delete();
    mem_q.delete();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    instr_ready = 1'b1;
    mem_lat     = 1;
    base        = n_pops;
    tick();
    chk("restart_req0", {31'b0, s_req}, 32'h1);
    chk("restart_addr0", s_addr, RST_PC);
    tick();
    chk("restart_addr1", s_addr, 32'h0000_0000);
    tick();
    chk("restart_ipc0", s_ipc, RST_PC);
    tick();
    chk("restart_ipc1", s_ipc, 32'h0000_0000);
    chk("restart_pops", n_pops - base, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
